// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM handshake states, arbiter states, guard default.
package cpu_types_pkg;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DGNT = 2'd1,
      IGNT = 2'd2
   } arb_state_t;

   localparam int unsigned STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Unified RAM port arbiter between instruction fetch and data memory, data has priority.
// Optional fetch starvation guard enabled by defining STARVE_GUARD_EN.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned ADDR_W = 32
`ifdef STARVE_GUARD_EN
   ,parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
`endif
)(
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              err
);

   arb_state_t state, state_nxt;
   ramstate_t  rs;
   logic       data_req;
   logic       guard_fire;

   assign rs       = ramstate_t'(ramstate);
   assign data_req = dREN | dWEN;

`ifdef STARVE_GUARD_EN
   localparam logic [3:0] GUARD_LIM = 4'(STARVE_MAX);
   logic [3:0] gcnt;

   assign guard_fire = (gcnt >= GUARD_LIM) && iREN;

   // Counts data grants taken over a pending fetch; saturates rather than wrapping.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         gcnt <= 4'd0;
      end else if (state == IDLE) begin
         if (!iREN || state_nxt == IGNT)
            gcnt <= 4'd0;
         else if (state_nxt == DGNT && gcnt != 4'hF)
            gcnt <= gcnt + 4'd1;
      end
   end
`else
   assign guard_fire = 1'b0;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Sticky error flag; only reset clears it.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
         err <= 1'b0;
      else if ((state == DGNT || state == IGNT) && rs == ERROR)
         err <= 1'b1;
   end

   // Grant is held through BUSY/ERROR; released on ACCESS or when the owner aborts.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (guard_fire)
               state_nxt = IGNT;
            else if (data_req)
               state_nxt = DGNT;
            else if (iREN)
               state_nxt = IGNT;
         end
         DGNT: if (!data_req || rs == ACCESS) state_nxt = IDLE;
         IGNT: if (!iREN || rs == ACCESS)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RAM drive is gated by the live request so an abort drops enables immediately.
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         DGNT: begin
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
         end
         IGNT: begin
            ramREN   = iREN;
            ramaddr  = iaddr;
         end
         default: ;
      endcase
   end

   assign dwait = data_req & ~(state == DGNT && rs == ACCESS);
   assign iwait = iREN & ~(state == IGNT && rs == ACCESS);
   assign iload = ramload;
   assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default or STARVE_GUARD_EN build).
module tb_mem_arbiter;

   localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

   logic        CLK, nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic [1:0]  ramstate, rs_drv;
   logic        ram_auto;

   int n_tests = 0;
   int n_fail  = 0;

   // Directed RAM state, or a 1-cycle RAM that answers ACCESS to any enable.
   assign ramstate = ram_auto ? ((ramREN | ramWEN) ? S_ACC : S_FREE) : rs_drv;

   mem_arbiter dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_por();
      n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL por_ramREN: got %b exp 0", ramREN); end
      n_tests++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL por_ramWEN: got %b exp 0", ramWEN); end
      n_tests++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL por_ramaddr: got %h exp 0", ramaddr); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL por_err: got %b exp 0", err); end
      n_tests++; if (iwait !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL por_wait: got i=%b d=%b exp 0 0", iwait, dwait); end
   endtask

   task automatic test_instr_read();
      tick();
      iREN = 1'b1; iaddr = 32'h40; rs_drv = S_FREE; #1;
      n_tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL ir_c0: got ren=%b iwait=%b exp 0 1", ramREN, iwait); end
      for (int c = 1; c <= 2; c++) begin
         tick();
         rs_drv = S_BUSY; #1;
         n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin n_fail++; $display("FAIL ir_busy%0d: got ren=%b addr=%h exp 1 40", c, ramREN, ramaddr); end
         n_tests++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL ir_iwait_busy%0d: got %b exp 1", c, iwait); end
      end
      tick();
      rs_drv = S_ACC; ramload = 32'hDEADBEEF; #1;
      n_tests++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL ir_iwait_acc: got %b exp 0", iwait); end
      n_tests++; if (iload !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ir_iload: got %h exp deadbeef", iload); end
      tick();
      rs_drv = S_FREE; #1;
      n_tests++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL ir_turn: got ren=%b iwait=%b exp 0 1", ramREN, iwait); end
      iREN = 1'b0;
   endtask

   task automatic test_priority();
      tick();
      iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234; rs_drv = S_FREE;
      tick();
      rs_drv = S_ACC; #1;
      n_tests++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL pr_en: got wen=%b ren=%b exp 1 0", ramWEN, ramREN); end
      n_tests++; if (ramaddr !== 32'h80 || ramstore !== 32'h1234) begin n_fail++; $display("FAIL pr_bus: got addr=%h store=%h exp 80 1234", ramaddr, ramstore); end
      n_tests++; if (iwait !== 1'b1 || dwait !== 1'b0) begin n_fail++; $display("FAIL pr_wait: got i=%b d=%b exp 1 0", iwait, dwait); end
      tick();
      dWEN = 1'b0; rs_drv = S_FREE; #1;
      n_tests++; if (ramWEN !== 1'b0 || ramREN !== 1'b0) begin n_fail++; $display("FAIL pr_turn: got wen=%b ren=%b exp 0 0", ramWEN, ramREN); end
      tick();
      rs_drv = S_ACC; #1;
      n_tests++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || ramstore !== 32'h0) begin n_fail++; $display("FAIL pr_ignt: got ren=%b addr=%h store=%h exp 1 44 0", ramREN, ramaddr, ramstore); end
      n_tests++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL pr_iwait: got %b exp 0", iwait); end
      tick();
      iREN = 1'b0; rs_drv = S_FREE;
   endtask

   task automatic test_abort();
      tick();
      dREN = 1'b1; daddr = 32'h90; ramload = 32'h0BADF00D;
      tick();
      rs_drv = S_BUSY; #1;
      n_tests++; if (ramREN !== 1'b1 || dwait !== 1'b1) begin n_fail++; $display("FAIL ab_gnt: got ren=%b dwait=%b exp 1 1", ramREN, dwait); end
      n_tests++; if (dload !== 32'h0BADF00D) begin n_fail++; $display("FAIL ab_dload: got %h exp 0badf00d", dload); end
      dREN = 1'b0; #1;
      n_tests++; if (ramREN !== 1'b0 || dwait !== 1'b0) begin n_fail++; $display("FAIL ab_drop: got ren=%b dwait=%b exp 0 0", ramREN, dwait); end
      tick();
      dREN = 1'b1; #1;
      n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL ab_idle: got ren=%b exp 0", ramREN); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL ab_err: got %b exp 0", err); end
      dREN = 1'b0; rs_drv = S_FREE;
   endtask

   task automatic test_error();
      tick();
      iREN = 1'b1; iaddr = 32'h50;
      tick();
      rs_drv = S_ERR; #1;
      n_tests++; if (err !== 1'b0 || iwait !== 1'b1) begin n_fail++; $display("FAIL er_c1: got err=%b iwait=%b exp 0 1", err, iwait); end
      tick();
      #1;
      n_tests++; if (err !== 1'b1 || ramREN !== 1'b1 || iwait !== 1'b1) begin n_fail++; $display("FAIL er_hold: got err=%b ren=%b iwait=%b exp 1 1 1", err, ramREN, iwait); end
      tick();
      rs_drv = S_BUSY; #1;
      n_tests++; if (err !== 1'b1 || ramREN !== 1'b1) begin n_fail++; $display("FAIL er_busy: got err=%b ren=%b exp 1 1", err, ramREN); end
      tick();
      rs_drv = S_ACC; #1;
      n_tests++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL er_acc: got iwait=%b exp 0", iwait); end
      tick();
      iREN = 1'b0; rs_drv = S_FREE; #1;
      n_tests++; if (err !== 1'b1 || ramREN !== 1'b0) begin n_fail++; $display("FAIL er_sticky: got err=%b ren=%b exp 1 0", err, ramREN); end
   endtask

   task automatic test_reset();
      tick();
      dWEN = 1'b1; daddr = 32'hA0; dstore = 32'h55;
      tick();
      rs_drv = S_BUSY; #1;
      n_tests++; if (ramWEN !== 1'b1 || ramaddr !== 32'hA0) begin n_fail++; $display("FAIL rs_pre: got wen=%b addr=%h exp 1 a0", ramWEN, ramaddr); end
      #1 nRST = 1'b0; #1;
      n_tests++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_fail++; $display("FAIL rs_async: got wen=%b addr=%h store=%h exp 0 0 0", ramWEN, ramaddr, ramstore); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL rs_err: got %b exp 0", err); end
      dWEN = 1'b0; rs_drv = S_FREE;
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      dREN = 1'b1; #1;
      n_tests++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rs_idle: got ren=%b exp 0", ramREN); end
      dREN = 1'b0;
   endtask

   task automatic test_guard();
      int evt[32];
      int nev = 0;
      int ni  = 0;
      tick();
      ram_auto = 1'b1; dWEN = 1'b1; daddr = 32'hC0; iREN = 1'b1; iaddr = 32'hB0;
      for (int c = 0; c < 30; c++) begin
         #1;
         if (nev < 32) begin
            if (ramWEN === 1'b1) begin evt[nev] = 1; nev++; end
            else if (ramREN === 1'b1 && ramaddr === 32'hB0) begin evt[nev] = 2; nev++; ni++; end
         end
         tick();
      end
      dWEN = 1'b0; iREN = 1'b0; ram_auto = 1'b0;
      n_tests++; if (nev < 10) begin n_fail++; $display("FAIL gd_count: got %0d grants exp >=10", nev); end
      for (int i = 0; i < 10; i++) begin
`ifdef STARVE_GUARD_EN
         n_tests++; if (evt[i] != ((i % 5 == 4) ? 2 : 1)) begin n_fail++; $display("FAIL gd_seq%0d: got %0d exp %0d", i, evt[i], (i % 5 == 4) ? 2 : 1); end
`else
         n_tests++; if (evt[i] != 1) begin n_fail++; $display("FAIL gd_seq%0d: got %0d exp 1", i, evt[i]); end
`endif
      end
`ifndef STARVE_GUARD_EN
      n_tests++; if (ni != 0) begin n_fail++; $display("FAIL gd_noi: got %0d fetch grants exp 0", ni); end
`endif
   endtask

   initial begin
      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      rs_drv = S_FREE; ram_auto = 1'b0;
      #3;
      test_por();
      @(negedge CLK);
      nRST = 1'b1;
      test_instr_read();
      test_priority();
      test_abort();
      test_error();
      test_reset();
      test_guard();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
